// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, op
// encodings and controller state type.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arb_grant.sv
// Grant decision between two requesters, with a burst limit on requester 0
// so requester 1 cannot be starved.
module alu_arb_grant
  import alu_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant0,
  output logic grant1
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic [3:0] burst_q, burst_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && idle) begin
      if (req0_valid && (!req1_valid || burst_q != BURST_LIM)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end

    // Only count grants to 0 that actually made requester 1 wait
    burst_d = burst_q;
    if (grant0) begin
      burst_d = req1_valid ? burst_q + 4'd1 : 4'd0;
    end else if (grant1) begin
      burst_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q <= 4'd0;
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared AND/OR/ADD/SUB unit.
// Define ALU_ARBITER_FLAGS_EN to build the carry/overflow flag registers.
//
// state | meaning
// IDLE  | waiting; one requester may be granted and its operands latched
// EXEC  | ALU evaluates latched operands, result registered at the edge
// RESP  | response held for the granted requester until it is consumed
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req0_op,
  input  logic [1:0]        req1_op,
  output logic              resp0_valid,
  output logic              resp1_valid,
  input  logic              resp0_ready,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_carry,
  output logic              resp_ovf
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  alu_op_e           op_q, op_d;
  logic              id_q, id_d;
  logic              grant0, grant1;
  logic              resp_take;
  logic [DATA_W-1:0] b_eff, alu_res;
  logic [DATA_W:0]   sum;

  alu_arb_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .idle       (state_q == ST_IDLE),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = (state_q == ST_RESP) && !id_q;
  assign resp1_valid = (state_q == ST_RESP) && id_q;
  assign resp_result = result_q;
  assign resp_take   = id_q ? resp1_ready : resp0_ready;

  // SUB shares the adder as A + ~B + 1
  always_comb begin
    b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, (op_q == OP_SUB)};
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      default: alu_res = sum[DATA_W-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = alu_op_e'(req0_op);
          id_d    = 1'b0;
          state_d = ST_EXEC;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = alu_op_e'(req1_op);
          id_d    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_res;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (resp_take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_ARBITER_FLAGS_EN
  logic carry_q, carry_d, ovf_q, ovf_d, alu_carry, alu_ovf;

  always_comb begin
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    if (op_q == OP_ADD || op_q == OP_SUB) begin
      alu_carry = sum[DATA_W];
      // carry into the sign bit differs from carry out of it
      alu_ovf   = (a_q[DATA_W-1] ^ b_eff[DATA_W-1] ^ sum[DATA_W-1]) ^ sum[DATA_W];
    end
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (state_q == ST_EXEC) begin
      carry_d = alu_carry;
      ovf_d   = alu_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign resp_carry = carry_q;
  assign resp_ovf   = ovf_q;
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum[DATA_W];
  assign resp_carry     = 1'b0;
  assign resp_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model
// compared every cycle, plus directed operand cases with literal results.
module tb_alu_arbiter;

  localparam int MAX_BURST = 4;
`ifdef ALU_ARBITER_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_carry, resp_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_ovf(resp_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  function automatic void alu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v);
    longint sa, sb, s;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: begin
        u = {1'b0, a} + {1'b0, b};
        r = u[31:0];
        c = u[32];
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
  endfunction

  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_id = 0;
  int          m_burst = 0;
  logic [31:0] pend_r = '0, exp_r = '0;
  logic        pend_c = 1'b0, pend_v = 1'b0, exp_c = 1'b0, exp_v = 1'b0;
  int          model_grants[$];
  int          dut_grants[$];

  function automatic int exp_grant();
    if (!rst_n || m_busy) return -1;
    if (req0_valid && req1_valid) return (m_burst == MAX_BURST) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model_upd
    int g;
    logic [31:0] r;
    logic c, v;
    g = exp_grant();
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_burst <= 0;
      exp_r   <= '0;
      exp_c   <= 1'b0;
      exp_v   <= 1'b0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        if (g == 0) alu_model(req0_op, req0_a, req0_b, r, c, v);
        else        alu_model(req1_op, req1_a, req1_b, r, c, v);
        m_busy  <= 1'b1;
        m_age   <= 1;
        m_id    <= g;
        pend_r  <= r;
        pend_c  <= c;
        pend_v  <= v;
        m_burst <= (g == 0 && req1_valid) ? m_burst + 1 : 0;
        model_grants.push_back(g);
      end
    end else if (m_age == 1) begin
      m_age <= 2;
      exp_r <= pend_r;
      exp_c <= pend_c;
      exp_v <= pend_v;
    end else if ((m_id == 0 && resp0_ready) || (m_id == 1 && resp1_ready)) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    int g;
    g = exp_grant();
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("resp0_valid", resp0_valid, m_busy && m_age == 2 && m_id == 0);
    check("resp1_valid", resp1_valid, m_busy && m_age == 2 && m_id == 1);
    check("resp_result", resp_result, exp_r);
    check("resp_carry", resp_carry, exp_c & FLAGS);
    check("resp_ovf", resp_ovf, exp_v & FLAGS);
    if (req0_valid && req0_ready) dut_grants.push_back(0);
    if (req1_valid && req1_ready) dut_grants.push_back(1);
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output int wait_cyc,
                       output logic [31:0] r, output logic c, output logic v);
    logic got;
    int lat;
    r = '0; c = 1'b0; v = 1'b0; wait_cyc = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
      else wait_cyc++;
    end
    check("accept_seen", got, 1);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if ((id == 0) ? resp0_valid : resp1_valid) got = 1'b1;
    end
    check("resp_latency", lat, 2);
    r = resp_result; c = resp_carry; v = resp_ovf;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_valid", (id == 0) ? resp0_valid : resp1_valid, 1);
      check("stall_result", resp_result, r);
      check("stall_readys", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    if (id == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(posedge clk); #1;
    if (id == 0) resp0_ready = 1'b0; else resp1_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r;
    logic c, v;
    int w;
    logic got;
    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_op = 2'b00; req1_op = 2'b00;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    alu_model(2'b10, 32'h7FFF_FFFF, 32'h0000_0001, r, c, v);
    check("model_add_res", r, 32'h8000_0000);
    check("model_add_ovf", v, 1);
    alu_model(2'b11, 32'd5, 32'd3, r, c, v);
    check("model_sub_res", r, 32'd2);
    check("model_sub_carry", c, 1);
    alu_model(2'b11, 32'd0, 32'd1, r, c, v);
    check("model_sub_borrow", {c, v}, 0);

    // req1 waits (and its resp_ready is asserted but must be ignored) while req0 stalls in RESP
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'd0; req1_b = 32'd1;
    resp1_ready = 1'b1;
    issue(0, 2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 5, w, r, c, v);
    resp1_ready = 1'b0;
    check("add_res", r, 32'h8000_0000);
    check("add_carry", c, 0);
    check("add_ovf", v, FLAGS);

    issue(1, 2'b11, 32'd0, 32'd1, 0, w, r, c, v);
    check("sub_wait_after_handshake", w, 0);
    check("sub_neg_res", r, 32'hFFFF_FFFF);
    check("sub_neg_flags", {c, v}, 0);

    issue(1, 2'b11, 32'd5, 32'd3, 0, w, r, c, v);
    check("sub_res", r, 32'd2);
    check("sub_carry", c, FLAGS);
    check("sub_ovf", v, 0);

    issue(0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, w, r, c, v);
    check("and_res", r, 32'hF000_F000);
    check("and_flags", {c, v}, 0);

    issue(1, 2'b01, 32'h0F0F_0000, 32'h0000_00F0, 0, w, r, c, v);
    check("or_res", r, 32'h0F0F_00F0);

    issue(0, 2'b11, 32'h8000_0000, 32'd1, 0, w, r, c, v);
    check("sub_min_res", r, 32'h7FFF_FFFF);
    check("sub_min_carry", c, FLAGS);
    check("sub_min_ovf", v, FLAGS);

    issue(1, 2'b10, 32'hFFFF_FFFF, 32'd1, 0, w, r, c, v);
    check("add_wrap_res", r, 32'h0000_0000);
    check("add_wrap_carry", c, FLAGS);
    check("add_wrap_ovf", v, 0);

    // Both requesters saturating: burst limit forces every fifth grant to req1
    model_grants.delete();
    dut_grants.delete();
    req0_op = 2'b00; req0_a = 32'd1; req0_b = 32'd1;
    req1_op = 2'b01; req1_a = 32'd2; req1_b = 32'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    check("burst_count", dut_grants.size(), 10);
    check("burst_model_count", model_grants.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < dut_grants.size()) check($sformatf("burst_order_%0d", i), dut_grants[i], exp_order[i]);
      if (i < model_grants.size()) check($sformatf("burst_model_%0d", i), model_grants[i], exp_order[i]);
    end

    // Reset while an operation is in EXEC
    req0_op = 2'b10; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1'b1;
    end
    check("rst_exec_accept", got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    resp0_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_exec_valid", {resp0_valid, resp1_valid}, 0);
    check("rst_exec_result", resp_result, 0);
    check("rst_exec_flags", {resp_carry, resp_ovf}, 0);
    check("rst_exec_readys", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", {resp0_valid, resp1_valid}, 0);
      check("post_rst_result", resp_result, 0);
    end
    resp0_ready = 1'b0;

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
